// File: rtl/dj_audio_pkg.sv
// Shared audio definitions: loop length default, note codes, half-period table
// for a 100 MHz system clock, and the tone synthesiser state encoding.
package dj_audio_pkg;

  localparam int LEN_DEFAULT = 6250000;

  typedef logic [3:0] note_code_t;

  localparam note_code_t NOTE_REST = 4'd0;
  localparam note_code_t NOTE_C4   = 4'd1;
  localparam note_code_t NOTE_D4   = 4'd2;
  localparam note_code_t NOTE_E4   = 4'd3;
  localparam note_code_t NOTE_F4   = 4'd4;
  localparam note_code_t NOTE_G4   = 4'd5;
  localparam note_code_t NOTE_A4   = 4'd6;
  localparam note_code_t NOTE_B4   = 4'd7;
  localparam note_code_t NOTE_C5   = 4'd8;

  // Half periods in clk cycles at 100 MHz, C4..C6; entry 0 is the rest code.
  localparam logic [17:0] NOTE_HP [16] = '{
    18'd0,      18'd191113, 18'd170262, 18'd151686,
    18'd143172, 18'd127551, 18'd113636, 18'd101239,
    18'd95557,  18'd85131,  18'd75843,  18'd71586,
    18'd63776,  18'd56818,  18'd50619,  18'd47778
  };

  // IDLE: stopped | TONE: sounding part of slot | GAP: articulation silence
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/beat_note_rom.sv
// Melody ROM: one note code per slot; swap this file to change the tune.
module beat_note_rom
  import dj_audio_pkg::*;
(
  input  logic [3:0] i_note_idx,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = NOTE_REST;
    case (i_note_idx)
      4'd0:    o_code = NOTE_C4;
      4'd1:    o_code = NOTE_E4;
      4'd2:    o_code = NOTE_G4;
      4'd3:    o_code = NOTE_C5;
      4'd4:    o_code = NOTE_A4;
      4'd5:    o_code = NOTE_REST;
      4'd6:    o_code = NOTE_G4;
      4'd7:    o_code = NOTE_E4;
      4'd8:    o_code = NOTE_F4;
      4'd9:    o_code = NOTE_F4;
      4'd10:   o_code = NOTE_E4;
      4'd11:   o_code = NOTE_E4;
      4'd12:   o_code = NOTE_D4;
      4'd13:   o_code = NOTE_D4;
      4'd14:   o_code = NOTE_C4;
      default: o_code = NOTE_REST;
    endcase
  end

endmodule

// File: rtl/beat_tone_synth.sv
// Tracks the melody slot from the player's beat index and synthesises a
// volume-scaled square wave with a silent gap at the end of each slot.
module beat_tone_synth
  import dj_audio_pkg::*;
#(
  parameter int          LEN      = LEN_DEFAULT,
  parameter int          SLOT_LEN = 390625,
  parameter int          GAP_LEN  = 20000,
  parameter logic [15:0] AMP_STEP = 16'h0800,
  parameter int          HP_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] ibeat,
  input  logic        play_or_not,
  input  logic        pause,
  input  logic        mute,
  input  logic [2:0]  volume,
  output logic [15:0] audio_out,
  output logic [3:0]  note_idx,
  output logic        tone_active,
  output logic        sync_err
);

  localparam int SP_W      = $clog2(SLOT_LEN);
  localparam int NUM_SLOTS = LEN / SLOT_LEN;

  state_t         r_state;
  state_t         w_state_next;
  logic [25:0]    r_ibeat_prev;
  logic [SP_W-1:0] r_slot_pos;
  logic [SP_W-1:0] w_slot_pos_next;
  logic [3:0]     r_note_idx;
  logic [3:0]     w_note_idx_next;
  logic           r_sync_err;
  logic [17:0]    r_hp_cnt;
  logic           r_phase;
  logic [15:0]    r_audio;

  logic           w_step;
  logic           w_inc;
  logic           w_wrap;
  logic           w_resync;
  logic           w_restart;
  logic [3:0]     w_code;
  logic [17:0]    w_hp;
  logic           w_hp_last;
  logic [15:0]    w_amp;
  logic           w_sound_en;
  logic           w_tone_active;

  beat_note_rom u_rom (
    .i_note_idx (r_note_idx),
    .o_code     (w_code)
  );

  always_comb begin
    w_step   = (ibeat != r_ibeat_prev);
    w_inc    = w_step && (ibeat == r_ibeat_prev + 26'd1);
    w_wrap   = w_step && !w_inc && (ibeat == '0);
    w_resync = w_step && !w_inc && !w_wrap;
  end

  // Resync outranks wrap, which outranks the slot boundary.
  always_comb begin
    w_slot_pos_next = r_slot_pos;
    w_note_idx_next = r_note_idx;
    w_restart       = 1'b0;
    if (w_resync || w_wrap) begin
      w_slot_pos_next = '0;
      w_note_idx_next = '0;
      w_restart       = 1'b1;
    end else if (w_inc) begin
      if (r_slot_pos == SP_W'(SLOT_LEN - 1)) begin
        w_slot_pos_next = '0;
        w_note_idx_next = (r_note_idx == 4'(NUM_SLOTS - 1)) ? 4'd0 : r_note_idx + 4'd1;
        w_restart       = 1'b1;
      end else begin
        w_slot_pos_next = r_slot_pos + 1'b1;
      end
    end
  end

  always_comb begin
    w_hp      = NOTE_HP[w_code] >> HP_SHIFT;
    w_hp_last = (r_hp_cnt == w_hp - 18'd1);
    w_amp     = 16'(volume) * AMP_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!play_or_not) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = TONE;
        TONE:    if (w_slot_pos_next >= SP_W'(SLOT_LEN - GAP_LEN)) w_state_next = GAP;
        GAP:     if (w_restart) w_state_next = TONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_tone_active = (r_state == TONE) && !mute && !pause;
    w_sound_en    = w_tone_active && (w_code != NOTE_REST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ibeat_prev <= '0;
      r_slot_pos   <= '0;
      r_note_idx   <= '0;
      r_sync_err   <= 1'b0;
      r_hp_cnt     <= '0;
      r_phase      <= 1'b0;
      r_audio      <= '0;
    end else begin
      r_ibeat_prev <= ibeat;
      r_audio      <= w_sound_en ? (r_phase ? -w_amp : w_amp) : 16'd0;
      if (!play_or_not) begin
        r_slot_pos <= '0;
        r_note_idx <= '0;
        r_sync_err <= 1'b0;
        r_hp_cnt   <= '0;
        r_phase    <= 1'b0;
      end else begin
        r_slot_pos <= w_slot_pos_next;
        r_note_idx <= w_note_idx_next;
        if (w_resync) r_sync_err <= 1'b1;
        // Rests hold the counter so the next note starts on a clean phase.
        if (w_restart) begin
          r_hp_cnt <= '0;
          r_phase  <= 1'b0;
        end else if (!pause && (w_code != NOTE_REST)) begin
          if (w_hp_last) begin
            r_hp_cnt <= '0;
            r_phase  <= ~r_phase;
          end else begin
            r_hp_cnt <= r_hp_cnt + 18'd1;
          end
        end
      end
    end
  end

  assign audio_out   = r_audio;
  assign note_idx    = r_note_idx;
  assign tone_active = w_tone_active;
  assign sync_err    = r_sync_err;

endmodule

// File: doc/beat_tone_synth.md
Name: beat_tone_synth

Overview:
Consumes the beat index `ibeat` produced by the player control stage. It divides the 6,250,000-step loop into 16 note slots and looks up one note per slot from a melody ROM. It synthesises a square-wave tone at that note's pitch, scaled by volume, with a silent articulation gap at the end of each slot. Its registered signed sample feeds the audio DAC serializer downstream.

Parameters:
LEN, 6250000, loop length in ibeat steps; must equal the upstream player control LEN.
SLOT_LEN, 390625, ibeat steps per note slot; LEN/SLOT_LEN = 16 slots.
GAP_LEN, 20000, final ibeat steps of each slot forced silent; must be < SLOT_LEN.
AMP_STEP, 16'h0800, amplitude per volume unit.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ibeat  in  26  beat index from player control; advances by +1 per step or wraps to 0
play_or_not  in  1  0 = stopped: force idle and silence
pause  in  1  1 = paused: silence, hold all phase state
mute  in  1  1 = silence output only; internal state keeps running
volume  in  3  amplitude scale 0..7
audio_out  out  16  signed sample, registered
note_idx  out  4  current slot number 0..15
tone_active  out  1  1 while in TONE state and not muted/paused
sync_err  out  1  sticky; set on an illegal ibeat jump, cleared by reset or play_or_not=0

Behaviour:
- Reset (asynchronous, active-high) values: audio_out=0, note_idx=0, tone_active=0, sync_err=0, state=IDLE. Internal slot_pos, tone counter, ibeat_prev and phase are all cleared to 0.
- Step detection: the block registers ibeat_prev every cycle.
  - A step is ibeat != ibeat_prev.
  - Legal step: ibeat == ibeat_prev+1, or ibeat == 0.
  - Any other change sets sync_err and resyncs: note_idx=0, slot_pos=0.
- Slot tracking:
  - On a legal +1 step: slot_pos increments.
  - When slot_pos reaches SLOT_LEN-1, the next step sets slot_pos=0 and increments note_idx (mod 16).
  - ibeat==0 after a nonzero value (wrap) sets note_idx=0, slot_pos=0.
- States:
  - IDLE -> TONE on the first cycle play_or_not=1.
  - TONE -> GAP when slot_pos reaches SLOT_LEN-GAP_LEN.
  - GAP -> TONE on a slot boundary (and on a wrap or resync).
  - Any state -> IDLE when play_or_not=0. This also clears note_idx, slot_pos and sync_err.
- Note lookup: code = beat_note_rom[note_idx]. Code 0 = rest, which is treated as silent in TONE.
- Tone generator:
  - A half-period counter counts clk cycles, and the phase toggles when the counter reaches NOTE_HP[code]-1.
  - The counter and phase (phase=0 = positive half) reset on every slot boundary, wrap or resync.
  - The counter holds while pause=1.
- Output, registered with 1-cycle latency from state/inputs:
  - amp = volume*AMP_STEP, 16-bit unsigned (max 16'h3800, no overflow).
  - audio_out = phase ? -amp : +amp, two's complement, when state=TONE, code!=0, pause=0 and mute=0.
  - Otherwise audio_out=0.
- Simultaneous events: play_or_not=0 has priority over everything. Next priority is resync (illegal jump), then wrap, then slot boundary. Pause never changes slot state because ibeat does not advance during pause.
- Volume changes take effect on the next sample without a phase reset.

Decomposition:
- Package `dj_audio_pkg` holds:
  - the LEN default;
  - note code encoding (4-bit, 0 = rest);
  - NOTE_HP[16] half-period table in clk cycles for 100 MHz (e.g. C4 = 191113);
  - state enum IDLE/TONE/GAP.
- Sub-module `beat_note_rom` is a 16-entry combinational melody ROM (note_idx -> code), kept separate so melodies can be swapped.

Test Plan:
1. Reset asserted mid-TONE -> audio_out=0, note_idx=0, sync_err=0 immediately; everything stays 0 after release until play_or_not=1.
2. Sim overrides SLOT_LEN=100, GAP_LEN=10, volume=4. Set play_or_not=1 and ibeat counting from 0 each clk, with slot 0 set to a code with nonzero NOTE_HP -> audio_out=+16'h2000 for NOTE_HP cycles, then -16'h2000 (16'hE000), alternating.
3. Same setup, ibeat=90..99 -> audio_out=0 (GAP). At ibeat=100, note_idx=1 and the tone restarts with a positive phase.
4. pause=1 for 50 cycles with ibeat held -> audio_out=0 one cycle later. On pause=0 the tone resumes from the held counter/phase, and note_idx is unchanged.
5. ibeat wraps LEN-1 -> 0 -> note_idx=0, phase positive, sync_err stays 0.
6. ibeat jumps 37 -> 500 -> sync_err=1 (sticky), note_idx=0. Then play_or_not=0 -> sync_err=0, state=IDLE, audio_out=0.
